// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor conditioning block.
// Thresholds, timer widths and accumulator sizes live here.
package sensor_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [11:0] BATT_THRESH  = 12'hA98;
  localparam logic [11:0] BRAKE_THRESH = 12'h800;
  localparam logic [4:0]  CAD_MIN      = 5'd2;
  localparam logic [4:0]  CNT_MAX      = 5'd31;

  localparam int SMPL_W      = 16;
  localparam int SMPL_W_FAST = 8;
  localparam int WIN_W       = 24;
  localparam int WIN_W_FAST  = 12;
  localparam int CURR_ACC_W  = 14;
  localparam int TORQ_ACC_W  = 17;

  function automatic logic [4:0] sat_inc(
    input logic [4:0] v,
    input logic       inc
  );
    return (inc && v != CNT_MAX) ? v + 5'd1 : v;
  endfunction

endpackage

// File: rtl/cadence_meas.sv
// Cadence pulse synchronizer, edge detect, window timer
// and saturating per-window edge counter.
module cadence_meas
  import sensor_pkg::*;
#(
  parameter int WIN_BITS = WIN_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cadence_raw,
  output logic       cad_rise,
  output logic       win_end,
  output logic [4:0] cadence,
  output logic [4:0] cadence_nxt
);

  logic [2:0]          sync_q;
  logic [WIN_BITS-1:0] win_tmr;
  logic [4:0]          edge_cnt;
  logic [4:0]          edge_tot;

  assign cad_rise = sync_q[1] & ~sync_q[2];
  assign win_end  = &win_tmr;

  // an edge landing on win_end belongs to the ending window
  assign edge_tot    = sat_inc(edge_cnt, cad_rise);
  assign cadence_nxt = win_end ? edge_tot : cadence;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      win_tmr  <= '0;
      edge_cnt <= '0;
      cadence  <= '0;
    end else begin
      sync_q   <= {sync_q[1:0], cadence_raw};
      win_tmr  <= win_tmr + WIN_BITS'(1);
      edge_cnt <= win_end ? 5'd0 : edge_tot;
      cadence  <= cadence_nxt;
    end
  end

endmodule

// File: rtl/sensor_cond.sv
// Sensor conditioning: current/torque IIR filters, cadence
// measurement, battery and brake threshold flags.
module sensor_cond
  import sensor_pkg::*;
#(
  parameter int FAST_SIM = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] brake,
  input  logic [11:0] torque,
  input  logic        cadence_raw,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic [4:0]  cadence,
  output logic        not_pedaling,
  output logic        batt_low,
  output logic        brake_active,
  output logic        valid
);

  localparam int WIN_BITS = (FAST_SIM != 0) ? WIN_W_FAST : WIN_W;

  logic                  cad_rise;
  logic                  win_end;
  logic [4:0]            cadence_nxt;
  logic [SMPL_W-1:0]     smpl_tmr;
  logic                  curr_smpl;
  logic [CURR_ACC_W-1:0] curr_accum;
  logic [TORQ_ACC_W-1:0] torque_accum;
  state_t                state;
  state_t                state_nxt;
  logic                  valid_nxt;
  logic                  np_nxt;

  cadence_meas #(
    .WIN_BITS(WIN_BITS)
  ) u_cad (
    .clk        (clk),
    .rst        (rst),
    .cadence_raw(cadence_raw),
    .cad_rise   (cad_rise),
    .win_end    (win_end),
    .cadence    (cadence),
    .cadence_nxt(cadence_nxt)
  );

  assign curr_smpl = (FAST_SIM != 0)
                   ? &smpl_tmr[SMPL_W_FAST-1:0]
                   : &smpl_tmr;

  assign avg_curr   = curr_accum[13:2];
  assign avg_torque = torque_accum[16:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smpl_tmr     <= '0;
      curr_accum   <= '0;
      torque_accum <= '0;
    end else begin
      smpl_tmr <= smpl_tmr + SMPL_W'(1);
      if (curr_smpl)
        curr_accum <= curr_accum - (curr_accum >> 2)
                    + {2'b00, curr};
      if (cad_rise)
        torque_accum <= torque_accum - (torque_accum >> 5)
                      + {5'b00000, torque};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    np_nxt    = 1'b1;
    unique case (state)
      INIT: if (win_end) state_nxt = RUN;
      RUN:  state_nxt = RUN;
    endcase
    valid_nxt = (state_nxt == RUN);
    np_nxt    = (state_nxt == INIT) || (cadence_nxt < CAD_MIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid        <= 1'b0;
      not_pedaling <= 1'b1;
      batt_low     <= 1'b0;
      brake_active <= 1'b0;
    end else begin
      valid        <= valid_nxt;
      not_pedaling <= np_nxt;
      batt_low     <= (batt < BATT_THRESH);
      brake_active <= (brake > BRAKE_THRESH);
    end
  end

endmodule
